// File: rtl/display_scan_driver_if.sv
// Digit-scan bundle between the BCD source/anode driver side and display_scan_driver.
// master: the side that supplies BCD values and consumes the scan outputs.
// slave:  display_scan_driver itself.
interface display_scan_driver_if;
    logic [15:0] bcd_in;
    logic        load;
    logic        load_ack;
    logic [1:0]  sel;
    logic [3:0]  digit;
    logic        blank;
    logic        frame;
    logic        bcd_err;

    modport master (
        output bcd_in, load,
        input  load_ack, sel, digit, blank, frame, bcd_err
    );

    modport slave (
        input  bcd_in, load,
        output load_ack, sel, digit, blank, frame, bcd_err
    );
endinterface

// File: rtl/display_scan_driver.sv
// display_scan_driver: 4-digit multiplex timing for a DD.DD BCD display.
// A prescaler divides clk into one tick per digit slot; a slot FSM walks sel 0..3.
// BCD values are staged in a pending register and copied into the shadow
// register only at the frame boundary, so a frame never mixes two values.
// Optional feature macro: LEADING_ZERO_BLANK_EN (blank a zero leftmost digit).
//
// state  | meaning
// SLOT_0 | leftmost digit (sel 0) is being driven
// SLOT_1 | sel 1, digit ahead of the decimal point
// SLOT_2 | sel 2
// SLOT_3 | sel 3, rightmost; a tick here closes the frame
module display_scan_driver #(
    parameter int REFRESH_DIV = 100000,
    parameter int CNT_W       = 17
) (
    input  logic                  clk,
    input  logic                  rst_n,
    display_scan_driver_if.slave  bus
);

    typedef enum logic [1:0] {
        SLOT_0 = 2'd0,
        SLOT_1 = 2'd1,
        SLOT_2 = 2'd2,
        SLOT_3 = 2'd3
    } slot_t;

    slot_t             slot_q, slot_d;
    logic [CNT_W-1:0]  presc_q;
    logic              tick;
    logic              boundary;

    logic [15:0]       pending_q;
    logic              pend_v_q;
    logic [15:0]       shadow_q, shadow_d;
    logic              shadow_upd;

    logic [3:0]        digit_q, digit_d;
    logic              blank_q, blank_d;
    logic              frame_q;
    logic              ack_q;
    logic              err_q;
    logic [3:0]        nib;

`ifdef LEADING_ZERO_BLANK_EN
    localparam logic BLANK_RST = 1'b1;
`else
    localparam logic BLANK_RST = 1'b0;
`endif

    function automatic logic [3:0] pick(input logic [15:0] v, input slot_t s);
        logic [3:0] r;
        case (s)
            SLOT_0:  r = v[15:12];
            SLOT_1:  r = v[11:8];
            SLOT_2:  r = v[7:4];
            default: r = v[3:0];
        endcase
        return r;
    endfunction

    function automatic logic has_bad(input logic [15:0] v);
        return (v[15:12] > 4'd9) || (v[11:8] > 4'd9) ||
               (v[7:4]   > 4'd9) || (v[3:0]  > 4'd9);
    endfunction

    assign tick = (presc_q == CNT_W'(REFRESH_DIV - 1));

    // Prescaler: free-running 0..REFRESH_DIV-1, independent of load activity.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
        end else if (tick) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_q + 1'b1;
        end
    end

    // Slot state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q <= SLOT_0;
        end else begin
            slot_q <= slot_d;
        end
    end

    // Slot next-state: advance on tick; leaving SLOT_3 marks the frame boundary.
    always_comb begin
        slot_d   = slot_q;
        boundary = 1'b0;
        case (slot_q)
            SLOT_0: if (tick) slot_d = SLOT_1;
            SLOT_1: if (tick) slot_d = SLOT_2;
            SLOT_2: if (tick) slot_d = SLOT_3;
            SLOT_3: begin
                if (tick) begin
                    slot_d   = SLOT_0;
                    boundary = 1'b1;
                end
            end
            default: slot_d = SLOT_0;
        endcase
    end

    // Shadow next value: a load landing on the boundary bypasses pending.
    always_comb begin
        shadow_d   = shadow_q;
        shadow_upd = 1'b0;
        if (boundary) begin
            if (bus.load) begin
                shadow_d   = bus.bcd_in;
                shadow_upd = 1'b1;
            end else if (pend_v_q) begin
                shadow_d   = pending_q;
                shadow_upd = 1'b1;
            end
        end
    end

    // Digit/blank for the slot being entered, looked up from the post-boundary shadow.
    always_comb begin
        nib     = pick(shadow_d, slot_d);
        digit_d = nib;
        blank_d = 1'b0;
        if (nib > 4'd9) begin
            digit_d = 4'hF;
            blank_d = 1'b1;
        end
`ifdef LEADING_ZERO_BLANK_EN
        else if ((slot_d == SLOT_0) && (nib == 4'd0)) begin
            blank_d = 1'b1;
        end
`endif
    end

    // Load path: stage into pending, or consumed directly at the boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
            pend_v_q  <= 1'b0;
            ack_q     <= 1'b0;
        end else begin
            ack_q <= bus.load;
            if (boundary) begin
                pend_v_q <= 1'b0;
            end else if (bus.load) begin
                pending_q <= bus.bcd_in;
                pend_v_q  <= 1'b1;
            end
        end
    end

    // Shadow register and its sticky validity flag, both updated at the boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q <= '0;
            err_q    <= 1'b0;
        end else if (shadow_upd) begin
            shadow_q <= shadow_d;
            err_q    <= has_bad(shadow_d);
        end
    end

    // Registered scan outputs, changing on the same edge as sel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit_q <= 4'd0;
            blank_q <= BLANK_RST;
            frame_q <= 1'b0;
        end else begin
            frame_q <= boundary;
            if (tick) begin
                digit_q <= digit_d;
                blank_q <= blank_d;
            end
        end
    end

    assign bus.sel      = slot_q;
    assign bus.digit    = digit_q;
    assign bus.blank    = blank_q;
    assign bus.frame    = frame_q;
    assign bus.load_ack = ack_q;
    assign bus.bcd_err  = err_q;

endmodule

// File: tb/tb_display_scan_driver.sv
// Directed bench for display_scan_driver with REFRESH_DIV = 4 (16-cycle frame).
// Build with +define+LEADING_ZERO_BLANK_EN to cover the leading-zero option.
module tb_display_scan_driver;

`ifdef LEADING_ZERO_BLANK_EN
    localparam logic LZ_EN = 1'b1;
`else
    localparam logic LZ_EN = 1'b0;
`endif

    logic clk;
    logic rst_n;

    display_scan_driver_if bus();

    display_scan_driver #(.REFRESH_DIV(4), .CNT_W(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // n: edges to advance (load held for the first only); lz: blank only when zero-blanking is built in
    typedef struct {
        int          n;
        logic        ld;
        logic [15:0] bcd;
        logic [1:0]  s;
        logic [3:0]  d;
        logic        b;
        logic        lz;
        logic        f;
        logic        a;
        logic        e;
    } vec_t;

    vec_t vq[$];
    int   nvec;
    int   nerr;

    task automatic add(input int n, input logic ld, input logic [15:0] bcd,
                       input logic [1:0] s, input logic [3:0] d, input logic b,
                       input logic lz, input logic f, input logic a, input logic e);
        vec_t v;
        v.n = n; v.ld = ld; v.bcd = bcd; v.s = s; v.d = d;
        v.b = b; v.lz = lz; v.f = f; v.a = a; v.e = e;
        vq.push_back(v);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic [1:0] s, input logic [3:0] d,
                           input logic b, input logic f, input logic a, input logic e);
        chk({tag, " sel"},      int'(bus.sel),      int'(s));
        chk({tag, " digit"},    int'(bus.digit),    int'(d));
        chk({tag, " blank"},    int'(bus.blank),    int'(b));
        chk({tag, " frame"},    int'(bus.frame),    int'(f));
        chk({tag, " load_ack"}, int'(bus.load_ack), int'(a));
        chk({tag, " bcd_err"},  int'(bus.bcd_err),  int'(e));
    endtask

    initial begin
        bit found;
        nvec = 0;
        nerr = 0;
        bus.load   = 1'b0;
        bus.bcd_in = 16'h0;
        rst_n      = 1'b0;

        //     n  ld  bcd       s  d     b  lz f  a  e
        add(1, 0, 16'h0000, 0, 4'h0, 0, 1, 0, 0, 0); // p1
        add(3, 0, 16'h0000, 1, 4'h0, 0, 0, 0, 0, 0); // p4
        add(4, 0, 16'h0000, 2, 4'h0, 0, 0, 0, 0, 0); // p8
        add(4, 0, 16'h0000, 3, 4'h0, 0, 0, 0, 0, 0); // p12
        add(4, 0, 16'h0000, 0, 4'h0, 0, 1, 1, 0, 0); // p16 wrap
        add(1, 0, 16'h0000, 0, 4'h0, 0, 1, 0, 0, 0); // p17
        add(3, 0, 16'h0000, 1, 4'h0, 0, 0, 0, 0, 0); // p20
        add(1, 1, 16'h2537, 1, 4'h0, 0, 0, 0, 1, 0); // p21 load mid-frame
        add(1, 0, 16'h0000, 1, 4'h0, 0, 0, 0, 0, 0); // p22
        add(6, 0, 16'h0000, 3, 4'h0, 0, 0, 0, 0, 0); // p28 still old value
        add(4, 0, 16'h0000, 0, 4'h2, 0, 0, 1, 0, 0); // p32
        add(4, 0, 16'h0000, 1, 4'h5, 0, 0, 0, 0, 0); // p36
        add(1, 1, 16'h1111, 1, 4'h5, 0, 0, 0, 1, 0); // p37
        add(1, 1, 16'h2468, 1, 4'h5, 0, 0, 0, 1, 0); // p38 overwrite
        add(2, 0, 16'h0000, 2, 4'h3, 0, 0, 0, 0, 0); // p40
        add(4, 0, 16'h0000, 3, 4'h7, 0, 0, 0, 0, 0); // p44
        add(4, 0, 16'h0000, 0, 4'h2, 0, 0, 1, 0, 0); // p48
        add(4, 0, 16'h0000, 1, 4'h4, 0, 0, 0, 0, 0); // p52
        add(4, 0, 16'h0000, 2, 4'h6, 0, 0, 0, 0, 0); // p56
        add(4, 0, 16'h0000, 3, 4'h8, 0, 0, 0, 0, 0); // p60
        add(3, 0, 16'h0000, 3, 4'h8, 0, 0, 0, 0, 0); // p63
        add(1, 1, 16'h0999, 0, 4'h0, 0, 1, 1, 1, 0); // p64 load on boundary tick
        add(4, 0, 16'h0000, 1, 4'h9, 0, 0, 0, 0, 0); // p68
        add(4, 0, 16'h0000, 2, 4'h9, 0, 0, 0, 0, 0); // p72
        add(4, 0, 16'h0000, 3, 4'h9, 0, 0, 0, 0, 0); // p76
        add(1, 1, 16'h1A23, 3, 4'h9, 0, 0, 0, 1, 0); // p77
        add(3, 0, 16'h0000, 0, 4'h1, 0, 0, 1, 0, 1); // p80
        add(4, 0, 16'h0000, 1, 4'hF, 1, 0, 0, 0, 1); // p84 invalid nibble
        add(4, 0, 16'h0000, 2, 4'h2, 0, 0, 0, 0, 1); // p88
        add(4, 0, 16'h0000, 3, 4'h3, 0, 0, 0, 0, 1); // p92
        add(1, 1, 16'h1023, 3, 4'h3, 0, 0, 0, 1, 1); // p93
        add(3, 0, 16'h0000, 0, 4'h1, 0, 0, 1, 0, 0); // p96 err clears
        add(4, 0, 16'h0000, 1, 4'h0, 0, 0, 0, 0, 0); // p100 zero at sel1 shown
        add(4, 0, 16'h0000, 2, 4'h2, 0, 0, 0, 0, 0); // p104
        add(4, 0, 16'h0000, 3, 4'h3, 0, 0, 0, 0, 0); // p108

        #3;
        chk_all("reset", 2'd0, 4'h0, LZ_EN, 1'b0, 1'b0, 1'b0);
        #9 rst_n = 1'b1;   // t=12, between edges

        for (int i = 0; i < vq.size(); i++) begin
            bus.load = vq[i].ld;
            if (vq[i].ld) bus.bcd_in = vq[i].bcd;
            step();
            bus.load = 1'b0;
            for (int k = 1; k < vq[i].n; k++) step();
            chk_all($sformatf("vec%0d", i), vq[i].s, vq[i].d,
                    vq[i].b | (vq[i].lz & LZ_EN), vq[i].f, vq[i].a, vq[i].e);
        end

        // Async reset during sel 2 with a pending value outstanding.
        found = 1'b0;
        for (int k = 0; k < 16 && !found; k++) begin
            step();
            if (bus.sel == 2'd2) found = 1'b1;
        end
        chk("reach sel2", int'(found), 1);
        bus.bcd_in = 16'h5555;
        bus.load   = 1'b1;
        step();
        bus.load = 1'b0;
        chk("pre-reset ack", int'(bus.load_ack), 1);
        #2 rst_n = 1'b0;
        #1;
        chk_all("async rst", 2'd0, 4'h0, LZ_EN, 1'b0, 1'b0, 1'b0);
        step();
        step();
        #2 rst_n = 1'b1;

        // Restart: sel from 0, pending 5555 discarded, one frame pulse at edge 16.
        for (int k = 1; k <= 20; k++) begin
            logic [1:0] es;
            step();
            es = 2'((k / 4) % 4);
            chk_all($sformatf("restart%0d", k), es, 4'h0,
                    LZ_EN & (es == 2'd0), (k == 16), 1'b0, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got no finish expected finish by 20000");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/display_scan_driver.md
Name: display_scan_driver

Overview:
- Multiplex-timing stage that sits directly upstream of the 4-digit anode/decimal-point driver.
- Divides the system clock into a per-digit refresh tick and cycles a 2-bit digit select, sel = 0..3. sel 0 is the leftmost digit; the decimal point follows sel 1, giving the format DD.DD.
- Double-buffers a 4-digit BCD temperature value and presents the BCD nibble of the selected digit to the segment decoder.
- New values take effect only at frame boundaries, so the display never tears.

Parameters:
- REFRESH_DIV, 100000: clock cycles per digit slot. Legal range is 2 or more.
- CNT_W, 17: prescaler counter width. Must satisfy 2^CNT_W >= REFRESH_DIV.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- bcd_in  input  16  four BCD digits. [15:12] maps to sel 0 (leftmost), [3:0] maps to sel 3.
- load  input  1  single-cycle request to capture bcd_in.
- load_ack  output  1  one-cycle pulse, registered, the cycle after load is captured.
- sel  output  2  digit select to the anode driver.
- digit  output  4  BCD nibble for the current sel.
- blank  output  1  1 means the decoder must blank all segments for this slot.
- frame  output  1  one-cycle pulse when sel wraps from 3 to 0.
- bcd_err  output  1  sticky flag: the active frame value contains a nibble greater than 9.

Behaviour:
- Reset (async assert, sync-style release) sets:
  - prescaler = 0, sel = 0;
  - pending = 0, pend_v = 0, shadow = 0;
  - digit = 0, blank = 0, frame = 0, load_ack = 0, bcd_err = 0.
- Reset mid-frame aborts the frame and discards any pending value.
- Prescaler:
  - Counts 0..REFRESH_DIV-1, then wraps to 0.
  - tick is asserted internally when prescaler == REFRESH_DIV-1.
- On tick: sel <= sel+1 (mod 4). When sel == 3, sel <= 0 and frame pulses in the cycle sel becomes 0.
- Load path:
  - load high: pending <= bcd_in, pend_v <= 1, load_ack pulses next cycle.
  - A second load before the boundary overwrites pending; the last one wins and each load is acked.
- Frame boundary (tick while sel == 3):
  - If pend_v: shadow <= pending, pend_v <= 0.
  - If load coincides with the boundary tick: shadow <= bcd_in directly, pend_v <= 0, load_ack still pulses.
- digit and blank are registered and update on the same edge as sel. Each slot's digit/blank always corresponds to its own sel value; there is zero skew between sel and digit.
  - digit = shadow nibble indexed by the next sel.
  - At reset and on the first slot, digit = shadow[15:12] = 0.
- Invalid nibble (greater than 9):
  - digit is forced to 4'hF and blank = 1 for that slot.
  - bcd_err is set when such a value enters shadow and cleared when a value with all nibbles 9 or below enters shadow.
- No tick is lost or duplicated across load or boundary events. Frame period is exactly 4*REFRESH_DIV cycles.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined: in slot sel 0 only, blank = 1 when shadow[15:12] == 0. Digits at sel 1..3 are never zero-blanked, so the digit before the decimal point always shows. After reset with shadow = 0, blank = 1 at sel 0.
- Undefined: blank is asserted only for invalid nibbles, and zeros display normally.

Test Plan:
- REFRESH_DIV=4, no load after reset -> sel steps 0,1,2,3,0 every 4 cycles; frame pulses once per 16 cycles; digit = 0 in every slot; load_ack = 0.
- load bcd_in=16'h2537 mid-frame at sel=1 -> load_ack pulses next cycle; digit stays 0 until the wrap; next frame shows digit 2,5,3,7 at sel 0..3.
- Two loads in one frame, 16'h1111 then 16'h2468 -> both acked; only 2,4,6,8 ever appears.
- load 16'h0999 on the boundary tick -> the frame starting that edge shows 0,9,9,9. With LEADING_ZERO_BLANK_EN, blank = 1 at sel 0 only. Without it, blank = 0 throughout.
- load 16'h1A23 -> at sel 1: digit = F, blank = 1; bcd_err = 1 after the boundary. Then load 16'h1023 -> bcd_err clears at the next boundary.
- Assert rst_n low at sel=2 with pend_v=1 -> all outputs return to reset values immediately (async); after release, the count restarts at sel 0 and the pending value is never shown.
